// File: rtl/jk_ff_sync.sv
// Rising-edge JK flip-flop bank with synchronous clear/preset and complement output.
// Optional simulation checks are compiled in when JK_FF_SYNC_ASSERT_EN is defined.
module jk_ff_sync #(
   parameter int WIDTH = 1
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             PR,
   input  logic [WIDTH-1:0] J,
   input  logic [WIDTH-1:0] K,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] P
);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;

   // Per bit: J sets when Q=0, and ~K keeps Q=1. This covers hold, set, reset and toggle.
   always_comb begin
      q_next = (J & ~q_reg) | (~K & q_reg);
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         q_reg <= '0;
      end else if (PR) begin
         q_reg <= '1;
      end else begin
         q_reg <= q_next;
      end
   end

   assign Q = q_reg;
   assign P = ~q_reg;

`ifdef JK_FF_SYNC_ASSERT_EN
   logic seen_clr;

   always_ff @(posedge CLK) begin
      if (CLR === 1'b1) begin
         seen_clr <= 1'b1;
      end
      if ((seen_clr === 1'b1) && (P !== ~Q)) begin
         $error("jk_ff_sync: P is not the complement of Q (Q=%b P=%b)", Q, P);
      end
      if ((CLR === 1'b1) && (PR === 1'b1)) begin
         $warning("jk_ff_sync: CLR and PR both asserted, CLR takes priority");
      end
      if ($isunknown({J, K, CLR, PR})) begin
         $error("jk_ff_sync: unknown control input at clock edge (J=%b K=%b CLR=%b PR=%b)",
                J, K, CLR, PR);
      end
   end
`else
`endif

endmodule

// File: tb/tb_jk_ff_sync.sv
// Self-checking bench for jk_ff_sync (WIDTH=4): directed steps followed by random
// stimulus, all compared against a bit-wise JK truth-table reference.
module tb_jk_ff_sync;

   localparam int W = 4;

   logic         CLK;
   logic         CLR;
   logic         PR;
   logic [W-1:0] J;
   logic [W-1:0] K;
   logic [W-1:0] Q;
   logic [W-1:0] P;

   logic [W-1:0] exp_q;
   int           checks;
   int           passes;

   jk_ff_sync #(.WIDTH(W)) dut (
      .CLK (CLK),
      .CLR (CLR),
      .PR  (PR),
      .J   (J),
      .K   (K),
      .Q   (Q),
      .P   (P)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [W-1:0] ref_next(input logic [W-1:0] q, input logic clr,
                                             input logic pr, input logic [W-1:0] j,
                                             input logic [W-1:0] k);
      logic [W-1:0] r;
      if (clr) return '0;
      if (pr) return '1;
      for (int i = 0; i < W; i++) begin
         case ({j[i], k[i]})
            2'b00:   r[i] = q[i];
            2'b01:   r[i] = 1'b0;
            2'b10:   r[i] = 1'b1;
            default: r[i] = ~q[i];
         endcase
      end
      return r;
   endfunction

   task automatic check(input string tag);
      checks++;
      assert (Q === exp_q) passes++;
      else $error("FAIL %s q: observed %b expected %b", tag, Q, exp_q);
      checks++;
      assert (P === ~exp_q) passes++;
      else $error("FAIL %s p: observed %b expected %b", tag, P, ~exp_q);
   endtask

   // Drive on the falling edge, let one rising edge sample, then check just after it.
   task automatic step(input logic clr, input logic pr, input logic [W-1:0] j,
                       input logic [W-1:0] k, input string tag);
      @(negedge CLK);
      CLR = clr;
      PR  = pr;
      J   = j;
      K   = k;
      exp_q = ref_next(exp_q, clr, pr, j, k);
      @(posedge CLK);
      #1;
      check(tag);
   endtask

   initial begin
      logic         rc;
      logic         rp;
      logic [W-1:0] rj;
      logic [W-1:0] rk;

      checks = 0;
      passes = 0;
      exp_q  = 'x;
      CLR = 1'b0;
      PR  = 1'b0;
      J   = '0;
      K   = '0;

      // reset then hold
      step(1'b1, 1'b0, 4'h0, 4'h0, "reset");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 4'h0, "hold0");

      // set then reset
      step(1'b0, 1'b0, 4'hF, 4'h0, "set");
      step(1'b0, 1'b0, 4'h0, 4'hF, "clear_k");

      // sustained toggle: 1,0,1,0
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'hF, 4'hF, "toggle");

      // clear during toggling, then resume from 0
      step(1'b0, 1'b0, 4'hF, 4'hF, "toggle_to1");
      step(1'b1, 1'b0, 4'hF, 4'hF, "clr_mid_toggle");
      step(1'b0, 1'b0, 4'hF, 4'hF, "toggle_resume");

      // CLR beats PR, then PR beats K
      step(1'b1, 1'b1, 4'h0, 4'h0, "clr_over_pr");
      step(1'b0, 1'b1, 4'h0, 4'hF, "pr_over_k");

      // mixed per-bit modes from zero
      step(1'b1, 1'b0, 4'h0, 4'h0, "reset2");
      step(1'b0, 1'b0, 4'b1010, 4'b0110, "mixed1");
      step(1'b0, 1'b0, 4'b1010, 4'b0110, "mixed2");
      step(1'b0, 1'b0, 4'b0101, 4'b1001, "mixed3");

      for (int n = 0; n < 200; n++) begin
         rc = ($urandom_range(0, 15) == 0);
         rp = ($urandom_range(0, 11) == 0);
         rj = W'($urandom);
         rk = W'($urandom);
         step(rc, rp, rj, rk, "random");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
